// File: rtl/zynq_ps_regbank.sv
// PS<->PL register bank: RW control, RO status, clear-on-read events with irq,
// and a buffer-lock handshake that write-protects a PL buffer for PS readout.
module zynq_ps_regbank #(
    parameter int DATA_W   = 32,
    parameter int NUM_CTRL = 8,
    parameter int NUM_STAT = 8,
    parameter int EVT_W    = 8,
    parameter int ADDR_W   = $clog2(NUM_CTRL + NUM_STAT + 2)
) (
    input  logic                         ps_clk,
    input  logic                         ps_rstn,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/8-1:0]          wr_strb,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic [NUM_CTRL*DATA_W-1:0]   ctrl_out,
    input  logic [NUM_STAT*DATA_W-1:0]   stat_in,
    input  logic [EVT_W-1:0]             evt_in,
    output logic                         irq,
    output logic                         buf_wp,
    input  logic                         buf_ready
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LOCK_A = ADDR_W'(NUM_CTRL + NUM_STAT);
    localparam logic [ADDR_W-1:0] EVT_A  = ADDR_W'(NUM_CTRL + NUM_STAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    logic [NUM_CTRL*DATA_W-1:0] ctrl_r;
    logic [DATA_W-1:0]          rd_data_r;
    logic                       rd_valid_r;
    logic [EVT_W-1:0]           evt_r;
    logic                       irq_r;
    logic                       buf_wp_r;
    lock_state_t                state_r;
    lock_state_t                state_next_s;
    logic [EVT_W-1:0]           evt_next_s;
    logic [DATA_W-1:0]          ctrl_sel_s;
    logic [DATA_W-1:0]          stat_sel_s;
    logic [DATA_W-1:0]          rd_mux_s;
    logic                       lock_wr_s;
    logic                       evt_clr_s;

    assign lock_wr_s = wr_en & (wr_addr == LOCK_A) & wr_strb[0];
    assign evt_clr_s = rd_en & (rd_addr == EVT_A);

    // Read mux: one-hot OR of the decoded sources, unmapped addresses fall through to zero
    always_comb begin
        ctrl_sel_s = {DATA_W{1'b0}};
        stat_sel_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CTRL; i++) begin
            ctrl_sel_s = ctrl_sel_s | ((rd_addr == ADDR_W'(i)) ?
                         ctrl_r[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            stat_sel_s = stat_sel_s | ((rd_addr == ADDR_W'(NUM_CTRL + i)) ?
                         stat_in[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
        end
        rd_mux_s = ctrl_sel_s | stat_sel_s
                 | ((rd_addr == LOCK_A) ? DATA_W'({state_r == ST_LOCKED, buf_wp_r}) : {DATA_W{1'b0}})
                 | ((rd_addr == EVT_A)  ? DATA_W'(evt_r) : {DATA_W{1'b0}});
    end

    // Sticky events: a clearing read drops old bits, but same-cycle arrivals survive
    always_comb begin
        evt_next_s = (evt_clr_s ? {EVT_W{1'b0}} : evt_r) | evt_in;
    end

    // Lock handshake next-state; an abort write in DRAIN wins over buf_ready
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lock_wr_s && (wr_data[0] == 1'b1)) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (lock_wr_s && (wr_data[0] == 1'b0)) begin
                    state_next_s = ST_IDLE;
                end else if (buf_ready) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_LOCKED: begin
                if (lock_wr_s && (wr_data[0] == 1'b0)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control registers with per-byte write enables
    always_ff @(posedge ps_clk or negedge ps_rstn) begin
        if (!ps_rstn) begin
            ctrl_r <= {(NUM_CTRL*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_en && (wr_addr == ADDR_W'(i)) && wr_strb[b]) begin
                        ctrl_r[i*DATA_W + b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered read port, data forced to zero outside the valid pulse
    always_ff @(posedge ps_clk or negedge ps_rstn) begin
        if (!ps_rstn) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_W{1'b0}};
        end else begin
            rd_valid_r <= rd_en;
            rd_data_r  <= rd_en ? rd_mux_s : {DATA_W{1'b0}};
        end
    end

    // Event register and interrupt, updated on the same edge
    always_ff @(posedge ps_clk or negedge ps_rstn) begin
        if (!ps_rstn) begin
            evt_r <= {EVT_W{1'b0}};
            irq_r <= 1'b0;
        end else begin
            evt_r <= evt_next_s;
            irq_r <= |evt_next_s;
        end
    end

    // Lock state and write-protect, which moves on the same edge as the state
    always_ff @(posedge ps_clk or negedge ps_rstn) begin
        if (!ps_rstn) begin
            state_r  <= ST_IDLE;
            buf_wp_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            buf_wp_r <= (state_next_s != ST_IDLE);
        end
    end

    assign ctrl_out = ctrl_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign irq      = irq_r;
    assign buf_wp   = buf_wp_r;

endmodule
